pi_encoder: RTL and testbench
=============================

PI_ENCODER -- requirements
Module: pi_encoder

Interface
REQ-001 The block SHALL have no parameters: 8 levels, fixed 3-bit level code.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req  in  [0:7]  level-sensitive interrupt requests; bit 0 = highest priority, bit 7 = lowest.
REQ-005 en  in  [0:7]  per-level enable mask; a request counts only when its en bit is 1.
REQ-006 ack  in  1  consumer accepts the offered level; meaningful only while valid=1.
REQ-007 dismiss  in  1  single-cycle pulse: service of the current highest in-progress level is complete.
REQ-008 valid  out  1  an encoded level is being offered.
REQ-009 level  out  [0:2]  binary index of the offered level; 3'd0 = bit 0.
REQ-010 inProgress  out  [0:7]  levels acknowledged and not yet dismissed.
REQ-011 dismissErr  out  1  one-cycle pulse: dismiss arrived with inProgress all zero.

Function
REQ-012 The block SHALL implement a 2-state FSM: IDLE and OFFER.
REQ-013 Eligible set: req & en, restricted to levels strictly higher in priority than the highest set inProgress bit; all of req & en when inProgress is zero.
REQ-014 IDLE: if the eligible set is non-empty at edge N, the block SHALL load level with the lowest-index eligible bit and enter OFFER, giving valid=1 from cycle N+1 (one-cycle latency).
REQ-015 IDLE with an empty eligible set: the block SHALL stay in IDLE with valid=0 and level unchanged.
REQ-016 OFFER: level SHALL stay stable until the offer ends; a later, higher-priority request SHALL NOT preempt it.
REQ-017 OFFER with ack=1: at that edge the block SHALL set inProgress[level], clear valid, and return to IDLE; ack with valid=0 SHALL be ignored.
REQ-018 OFFER with ack=0 and req[level]=0 or en[level]=0 (withdrawal): the block SHALL clear valid and return to IDLE without setting inProgress.
REQ-019 ack and withdrawal in the same cycle: ack SHALL win and the level SHALL be marked in progress.
REQ-020 dismiss=1 SHALL clear the lowest-index set bit of inProgress, as sampled before any same-cycle ack update.
REQ-021 dismiss and ack in the same cycle: both SHALL apply. Because the new level is always higher than any prior in-progress level, the net result is prior-highest cleared and the new level set.
REQ-022 dismiss with inProgress zero: the block SHALL leave state unchanged and pulse dismissErr high for exactly one cycle.
REQ-023 After return to IDLE, the next offer SHALL use the eligible set recomputed from current inputs; back-to-back offers are therefore at most one IDLE cycle apart.
REQ-024 inProgress SHALL change only by ack or dismiss, never by changes on req or en.

Reset
REQ-025 While rst_n=0 the block SHALL force: state=IDLE, valid=0, level=3'd0, inProgress=8'h00, dismissErr=0.
REQ-026 Reset mid-OFFER SHALL drop the offer immediately (asynchronously) with no inProgress update.
REQ-027 The first offer after rst_n rises SHALL occur no earlier than the second rising edge after deassertion.

Verification
REQ-028 req=8'b0010_0100, en=8'hFF, inProgress=0 -> next cycle: valid=1, level=3'd2; ack -> inProgress=8'b0010_0000, then level=3'd5 is NOT offered (lower than in-progress level 2).
REQ-029 Offer level 5 outstanding, req[1] rises -> level stays 3'd5 until ack; after ack (inProgress=8'b0000_0100) the block offers level=3'd1 two cycles later.
REQ-030 Offer level 3, req[3] drops before ack -> valid=0 next cycle, inProgress unchanged at 8'h00.
REQ-031 inProgress=8'b0001_0000, offer level 1, ack and dismiss in the same cycle -> inProgress=8'b0100_0000.
REQ-032 dismiss with inProgress=0 -> dismissErr=1 for one cycle, all other outputs unchanged; rst_n pulsed low mid-OFFER -> valid=0 and inProgress=0 without waiting for a clock edge.

Source files
------------

// File: rtl/pi_encoder.sv
// rtl/pi_encoder.sv - 8-level priority interrupt encoder with in-progress tracking
// Bit 0 is the highest priority on every level-indexed vector.
module pi_encoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:7] req,
  input  logic [0:7] en,
  input  logic       ack,
  input  logic       dismiss,
  output logic       valid,
  output logic [0:2] level,
  output logic [0:7] inProgress,
  output logic       dismissErr
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  state_e     state_q;
  logic       valid_q;
  logic [0:2] level_q;
  logic [0:7] ip_q;
  logic [0:7] ip_d;
  logic       derr_q;
  logic       armed_q;

  logic [0:7] ceil_mask;
  logic [0:7] elig;
  logic       elig_any;
  logic [0:2] elig_idx;
  logic [0:7] ip_dismissed;
  logic       withdrawn;

  // Only levels above the highest one already in service may be offered.
  always_comb begin
    logic seen;
    seen      = 1'b0;
    ceil_mask = '1;
    for (int i = 0; i < 8; i++) begin
      if (ip_q[i]) seen = 1'b1;
      if (seen) ceil_mask[i] = 1'b0;
    end
  end

  assign elig     = req & en & ceil_mask;
  assign elig_any = |elig;

  always_comb begin
    elig_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (elig[i]) elig_idx = 3'(i);
    end
  end

  always_comb begin
    logic seen;
    seen         = 1'b0;
    ip_dismissed = ip_q;
    for (int i = 0; i < 8; i++) begin
      if (ip_q[i] && !seen) begin
        ip_dismissed[i] = 1'b0;
        seen            = 1'b1;
      end
    end
  end

  // Dismiss acts on the pre-ack view; a same-cycle ack then adds the new level.
  always_comb begin
    ip_d = ip_q;
    if (dismiss) ip_d = ip_dismissed;
    if (state_q == OFFER && ack) ip_d[level_q] = 1'b1;
  end

  assign withdrawn = !req[level_q] || !en[level_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      level_q <= 3'd0;
      ip_q    <= 8'h00;
      derr_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      ip_q    <= ip_d;
      derr_q  <= dismiss && (ip_q == 8'h00);
      case (state_q)
        IDLE: begin
          // The armed flag holds off offers until the second edge after reset.
          if (armed_q && elig_any) begin
            state_q <= OFFER;
            valid_q <= 1'b1;
            level_q <= elig_idx;
          end
        end
        OFFER: begin
          if (ack || withdrawn) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign valid      = valid_q;
  assign level      = level_q;
  assign inProgress = ip_q;
  assign dismissErr = derr_q;

endmodule

// File: tb/tb_pi_encoder.sv
// tb/tb_pi_encoder.sv - directed self-checking bench for pi_encoder
module tb_pi_encoder;

  logic       clk;
  logic       rst_n;
  logic [0:7] req;
  logic [0:7] en;
  logic       ack;
  logic       dismiss;
  logic       valid;
  logic [0:2] level;
  logic [0:7] inProgress;
  logic       dismissErr;

  int n_checks;
  int n_fails;

  pi_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .en         (en),
    .ack        (ack),
    .dismiss    (dismiss),
    .valid      (valid),
    .level      (level),
    .inProgress (inProgress),
    .dismissErr (dismissErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req     = 8'h00;
    en      = 8'hFF;
    ack     = 1'b0;
    dismiss = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b0;
    req      = 8'b0010_0100;
    en       = 8'hFF;
    ack      = 1'b0;
    dismiss  = 1'b0;
    tick();
    tick();
    check_eq("rst_valid", valid, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_ip", inProgress, 8'h00);
    check_eq("rst_derr", dismissErr, 0);

    // Basic offer, ceiling by in-progress level, first-offer delay after reset
    rst_n = 1'b1;
    tick();
    check_eq("arm_delay_valid", valid, 0);
    tick();
    check_eq("r28_valid", valid, 1);
    check_eq("r28_level", level, 2);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_eq("r28_ack_valid", valid, 0);
    check_eq("r28_ack_ip", inProgress, 8'b0010_0000);
    tick();
    check_eq("r28_no_lvl5_a", valid, 0);
    tick();
    check_eq("r28_no_lvl5_b", valid, 0);
    check_eq("r28_ip_hold", inProgress, 8'b0010_0000);
    req = 8'h00;
    tick();
    check_eq("ip_ignores_req", inProgress, 8'b0010_0000);

    // No preemption while offering
    do_reset();
    req = 8'b0000_0100;
    tick();
    check_eq("r29_valid", valid, 1);
    check_eq("r29_level5", level, 5);
    req = 8'b0100_0100;
    tick();
    check_eq("r29_nopreempt_a", level, 5);
    tick();
    check_eq("r29_nopreempt_b", level, 5);
    check_eq("r29_still_valid", valid, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_eq("r29_ack_ip", inProgress, 8'b0000_0100);
    check_eq("r29_ack_valid", valid, 0);
    tick();
    check_eq("r29_next_valid", valid, 1);
    check_eq("r29_next_level", level, 1);

    // Withdrawal by req drop and by en drop
    do_reset();
    req = 8'b0001_0000;
    tick();
    check_eq("r30_valid", valid, 1);
    check_eq("r30_level", level, 3);
    req = 8'h00;
    tick();
    check_eq("r30_wd_valid", valid, 0);
    check_eq("r30_wd_ip", inProgress, 8'h00);
    req = 8'b0001_0000;
    tick();
    check_eq("en_wd_offer", valid, 1);
    en = 8'b1110_1111;
    tick();
    check_eq("en_wd_valid", valid, 0);
    check_eq("en_wd_ip", inProgress, 8'h00);
    en = 8'hFF;

    // Ack wins over same-cycle withdrawal
    tick();
    check_eq("ackwd_offer", valid, 1);
    req = 8'h00;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_eq("ackwd_ip", inProgress, 8'b0001_0000);
    check_eq("ackwd_valid", valid, 0);

    // Ack and dismiss in the same cycle
    req = 8'b0101_0000;
    tick();
    check_eq("r31_valid", valid, 1);
    check_eq("r31_level", level, 1);
    ack     = 1'b1;
    dismiss = 1'b1;
    tick();
    ack     = 1'b0;
    dismiss = 1'b0;
    check_eq("r31_ip", inProgress, 8'b0100_0000);
    check_eq("r31_derr", dismissErr, 0);

    // Dismiss clears the lowest-index set bit only
    req = 8'b1000_0000;
    tick();
    check_eq("lvl0_offer", level, 0);
    ack = 1'b1;
    tick();
    ack     = 1'b0;
    req     = 8'h00;
    check_eq("two_ip", inProgress, 8'b1100_0000);
    dismiss = 1'b1;
    tick();
    dismiss = 1'b0;
    check_eq("dismiss_top", inProgress, 8'b0100_0000);

    // Dismiss error and ignored ack while idle
    do_reset();
    dismiss = 1'b1;
    tick();
    dismiss = 1'b0;
    check_eq("r32_derr_pulse", dismissErr, 1);
    check_eq("r32_derr_valid", valid, 0);
    check_eq("r32_derr_ip", inProgress, 8'h00);
    tick();
    check_eq("r32_derr_clear", dismissErr, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_eq("idle_ack_ip", inProgress, 8'h00);
    check_eq("idle_ack_valid", valid, 0);

    // Asynchronous reset mid-offer with an in-progress level
    req = 8'b0001_0000;
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    req = 8'b0100_0000;
    tick();
    check_eq("pre_async_valid", valid, 1);
    check_eq("pre_async_ip", inProgress, 8'b0001_0000);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_valid", valid, 0);
    check_eq("async_ip", inProgress, 8'h00);
    check_eq("async_level", level, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
